// File: rtl/obstacle_scheduler.sv
// Frame-tick sequencer for a bank of obstacle movers: periodic move pulses, LFSR-placed spawns, difficulty ramp.
// All outputs registered; move pulses and spawn strobes last one clk cycle; enable low parks the FSM in S_IDLE.
module obstacle_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int SLOT_W       = 2,
  parameter int SPAWN_FRAMES = 60,
  parameter int START_DIV    = 4,
  parameter int LEVEL_SPAWNS = 8,
  parameter int X_MAX        = 608
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 frame_tick,
  input  logic [NUM_SLOTS-1:0] obstacle_done,
  output logic [NUM_SLOTS-1:0] obstacle_trigger,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [9:0]           spawn_x,
  output logic [NUM_SLOTS-1:0] active,
  output logic [3:0]           level
);
  localparam int SC_W = $clog2(SPAWN_FRAMES + 1);
  localparam int ST_W = $clog2(LEVEL_SPAWNS + 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SPAWN_FRAMES - 1);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(LEVEL_SPAWNS - 1);
  localparam logic [9:0]      X_LIM    = 10'(X_MAX);
  localparam logic [9:0]      X_WRAP   = 10'(X_MAX + 1);
  localparam logic [3:0]      DIV_INIT = 4'(START_DIV);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_MOVE, S_SPAWN} state_t;

  state_t                r_state, w_state;
  logic [9:0]            r_lfsr, w_lfsr, w_lfsr_r;
  logic [NUM_SLOTS-1:0]  r_trig, w_trig;
  logic                  r_spawn_vld, w_spawn_vld;
  logic [SLOT_W-1:0]     r_spawn_slot, w_spawn_slot, w_free_slot;
  logic [9:0]            r_spawn_x, w_spawn_x;
  logic [NUM_SLOTS-1:0]  r_active, w_active, w_free, w_onehot;
  logic [3:0]            r_level, w_level;
  logic [3:0]            r_move_cnt, w_move_cnt;
  logic [3:0]            r_cur_div, w_cur_div;
  logic [SC_W-1:0]       r_spawn_cnt, w_spawn_cnt;
  logic [ST_W-1:0]       r_total, w_total;
  logic                  r_pending, w_pending;

  always_comb begin
    w_lfsr   = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    w_lfsr_r = (r_lfsr <= X_LIM) ? r_lfsr : r_lfsr - X_WRAP;
    w_free   = ~r_active;
    w_free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_slot = SLOT_W'(i);
    end
  end

  always_comb begin
    w_state      = r_state;
    w_trig       = '0;
    w_spawn_vld  = 1'b0;
    w_spawn_slot = r_spawn_slot;
    w_spawn_x    = r_spawn_x;
    w_onehot     = '0;
    w_level      = r_level;
    w_move_cnt   = r_move_cnt;
    w_cur_div    = r_cur_div;
    w_spawn_cnt  = r_spawn_cnt;
    w_total      = r_total;
    w_pending    = r_pending;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state = S_COUNT;
      end
      S_COUNT: begin
        if (!enable) begin
          w_state = S_IDLE;
        end else if (frame_tick) begin
          w_spawn_cnt = (r_spawn_cnt == SC_LAST) ? r_spawn_cnt : r_spawn_cnt + 1'b1;
          w_pending   = (w_spawn_cnt == SC_LAST);
          // >= catches a count left above a period that a level-up just shortened
          if (r_move_cnt >= r_cur_div - 4'd1) begin
            w_move_cnt = '0;
            w_state    = S_MOVE;
          end else begin
            w_move_cnt = r_move_cnt + 4'd1;
            w_state    = w_pending ? S_SPAWN : S_COUNT;
          end
        end
      end
      S_MOVE: begin
        w_trig  = r_active;
        w_state = !enable ? S_IDLE : (r_pending ? S_SPAWN : S_COUNT);
      end
      S_SPAWN: begin
        if (|w_free) begin
          w_spawn_vld  = 1'b1;
          w_spawn_slot = w_free_slot;
          w_spawn_x    = {w_lfsr_r[9:2], 2'b00};
          w_onehot     = NUM_SLOTS'(1) << w_free_slot;
          w_spawn_cnt  = '0;
          if (r_total == ST_LAST) begin
            w_total   = '0;
            w_level   = (r_level == 4'd15) ? r_level : r_level + 4'd1;
            w_cur_div = (r_cur_div > 4'd1) ? r_cur_div - 4'd1 : r_cur_div;
          end else begin
            w_total = r_total + 1'b1;
          end
        end
        w_state = enable ? S_COUNT : S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_active = (r_active & ~obstacle_done) | w_onehot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= 10'h001;
      r_state      <= S_IDLE;
      r_trig       <= '0;
      r_spawn_vld  <= 1'b0;
      r_spawn_slot <= '0;
      r_spawn_x    <= '0;
      r_active     <= '0;
      r_level      <= '0;
      r_move_cnt   <= '0;
      r_cur_div    <= DIV_INIT;
      r_spawn_cnt  <= '0;
      r_total      <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr;
      if (clear) begin
        r_state      <= S_IDLE;
        r_trig       <= '0;
        r_spawn_vld  <= 1'b0;
        r_spawn_slot <= '0;
        r_spawn_x    <= '0;
        r_active     <= '0;
        r_level      <= '0;
        r_move_cnt   <= '0;
        r_cur_div    <= DIV_INIT;
        r_spawn_cnt  <= '0;
        r_total      <= '0;
        r_pending    <= 1'b0;
      end else begin
        r_state      <= w_state;
        r_trig       <= w_trig;
        r_spawn_vld  <= w_spawn_vld;
        r_spawn_slot <= w_spawn_slot;
        r_spawn_x    <= w_spawn_x;
        r_active     <= w_active;
        r_level      <= w_level;
        r_move_cnt   <= w_move_cnt;
        r_cur_div    <= w_cur_div;
        r_spawn_cnt  <= w_spawn_cnt;
        r_total      <= w_total;
        r_pending    <= w_pending;
      end
    end
  end

  assign obstacle_trigger = r_trig;
  assign spawn_valid      = r_spawn_vld;
  assign spawn_slot       = r_spawn_slot;
  assign spawn_x          = r_spawn_x;
  assign active           = r_active;
  assign level            = r_level;
endmodule
